// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO over a registered-read RAM, with standard or first-word-fall-through read,
// occupancy count, almost-full/empty thresholds, sticky overflow/underflow and synchronous flush.
module sync_fifo_fwft #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 64,
  parameter int FWFT          = 1,
  parameter int AFULL_THRESH  = DEPTH - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clr,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_rd_valid,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_almost_full,
  output logic                     o_almost_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow,
  output logic                     o_underflow,
  input  logic                     i_err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0] DEPTH_C = CW'(DEPTH);
  localparam logic [AW:0] AF_C    = CW'(AFULL_THRESH);
  localparam logic [AW:0] AE_C    = CW'(AEMPTY_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d, cnt_q, cnt_d;
  logic [WIDTH-1:0] ram_q, out_q;
  logic             ram_vld_q, ram_vld_d, out_vld_q, out_vld_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             full, empty, rd_avail, wr_acc, rd_acc, ram_rd, s1_move;

  always_comb begin
    full      = (cnt_q == DEPTH_C);
    empty     = (cnt_q == '0);
    rd_avail  = (FWFT != 0) ? out_vld_q : !empty;
    wr_acc    = i_wr_en && !full && !i_clr;
    rd_acc    = i_rd_en && rd_avail && !i_clr;
    ram_rd    = 1'b0;
    s1_move   = 1'b0;
    ram_vld_d = 1'b0;
    out_vld_d = 1'b0;
    if (FWFT != 0) begin
      // Prefetch: RAM word -> ram_q -> out_q; a pop frees the whole chain in one cycle.
      s1_move   = ram_vld_q && (!out_vld_q || rd_acc) && !i_clr;
      ram_rd    = (wptr_q != rptr_q) && (!ram_vld_q || s1_move) && !i_clr;
      ram_vld_d = ram_rd || (ram_vld_q && !s1_move);
      out_vld_d = s1_move || (out_vld_q && !rd_acc);
    end else begin
      ram_rd    = rd_acc;
      ram_vld_d = rd_acc;
    end
    wptr_d = wptr_q + CW'(wr_acc);
    rptr_d = rptr_q + CW'(ram_rd);
    cnt_d  = cnt_q + CW'(wr_acc) - CW'(rd_acc);
    if (i_clr) begin
      wptr_d    = '0;
      rptr_d    = '0;
      cnt_d     = '0;
      ram_vld_d = 1'b0;
      out_vld_d = 1'b0;
    end
    // A fresh error in the same cycle as i_err_clr keeps the flag set.
    ovf_d = (i_wr_en && full && !i_clr) || (ovf_q && !i_err_clr);
    udf_d = (i_rd_en && !rd_avail && !i_clr) || (udf_q && !i_err_clr);
  end

  always_ff @(posedge i_clk) begin
    if (wr_acc) mem[wptr_q[AW-1:0]] <= i_wr_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      ram_q     <= '0;
      out_q     <= '0;
      ram_vld_q <= 1'b0;
      out_vld_q <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      ram_vld_q <= ram_vld_d;
      out_vld_q <= out_vld_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      if (ram_rd)  ram_q <= mem[rptr_q[AW-1:0]];
      if (s1_move) out_q <= ram_q;
    end
  end

  assign o_rd_data      = (FWFT != 0) ? out_q : ram_q;
  assign o_rd_valid     = (FWFT != 0) ? out_vld_q : ram_vld_q;
  assign o_full         = full;
  assign o_empty        = empty;
  assign o_almost_full  = (cnt_q >= AF_C);
  assign o_almost_empty = (cnt_q <= AE_C);
  assign o_count        = cnt_q;
  assign o_overflow     = ovf_q;
  assign o_underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Directed bench: a standard-read and an FWFT instance (DEPTH=8, thresholds 6/2) share one stimulus.
module tb_sync_fifo_fwft;

  logic       clk = 1'b0, rst_n = 1'b1, clr = 1'b0, wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
  logic [7:0] wr_data = 8'h00;

  logic [7:0] a_data, b_data;
  logic       a_vld, a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
  logic       b_vld, b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
  logic [3:0] a_cnt, b_cnt;
  logic [6:0] a_st, b_st;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign a_st = {a_vld, a_full, a_empty, a_af, a_ae, a_ovf, a_udf};
  assign b_st = {b_vld, b_full, b_empty, b_af, b_ae, b_ovf, b_udf};

  sync_fifo_fwft #(.WIDTH(8), .DEPTH(8), .FWFT(0), .AFULL_THRESH(6), .AEMPTY_THRESH(2)) u_std (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_wr_en(wr_en), .i_wr_data(wr_data),
    .i_rd_en(rd_en), .o_rd_data(a_data), .o_rd_valid(a_vld), .o_full(a_full), .o_empty(a_empty),
    .o_almost_full(a_af), .o_almost_empty(a_ae), .o_count(a_cnt), .o_overflow(a_ovf),
    .o_underflow(a_udf), .i_err_clr(err_clr));

  sync_fifo_fwft #(.WIDTH(8), .DEPTH(8), .FWFT(1), .AFULL_THRESH(6), .AEMPTY_THRESH(2)) u_fwft (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_wr_en(wr_en), .i_wr_data(wr_data),
    .i_rd_en(rd_en), .o_rd_data(b_data), .o_rd_valid(b_vld), .o_full(b_full), .o_empty(b_empty),
    .o_almost_full(b_af), .o_almost_empty(b_ae), .o_count(b_cnt), .o_overflow(b_ovf),
    .o_underflow(b_udf), .i_err_clr(err_clr));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; wr_data = 8'h00;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (a_st !== 7'b0010100) begin n_fail++; $display("FAIL reset_std_status: got %b exp %b", a_st, 7'b0010100); end
    n_chk++; if (b_st !== 7'b0010100) begin n_fail++; $display("FAIL reset_fwft_status: got %b exp %b", b_st, 7'b0010100); end
    n_chk++; if ({a_cnt, b_cnt} !== 8'h00) begin n_fail++; $display("FAIL reset_count: got %h/%h exp 0/0", a_cnt, b_cnt); end
    n_chk++; if ({a_data, b_data} !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h/%h exp 0/0", a_data, b_data); end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_fill_overflow();
    int bad = 0;
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      step();
    end
    wr_en = 1'b0;
    n_chk++; if (a_st !== 7'b0101000 || a_cnt !== 4'd8) begin n_fail++; $display("FAIL fill_full: got %b cnt %0d exp 0101000 cnt 8", a_st, a_cnt); end
    wr_en = 1'b1; wr_data = 8'd9;
    step();
    wr_en = 1'b0;
    n_chk++; if (a_st !== 7'b0101010 || a_cnt !== 4'd8) begin n_fail++; $display("FAIL overflow: got %b cnt %0d exp 0101010 cnt 8", a_st, a_cnt); end
    rd_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (a_vld !== 1'b1 || a_data !== 8'(i)) bad++;
    end
    rd_en = 1'b0;
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL std_read_seq: got %0d bad reads exp 0", bad); end
    step();
    n_chk++; if (a_st !== 7'b0010110 || a_data !== 8'd8) begin n_fail++; $display("FAIL std_drained: got %b data %h exp 0010110 data 08", a_st, a_data); end
  endtask

  task automatic test_fwft_latency();
    do_reset();
    wr_en = 1'b1; wr_data = 8'hA5;
    step();
    wr_en = 1'b0;
    n_chk++; if (b_empty !== 1'b0 || b_vld !== 1'b0 || b_cnt !== 4'd1) begin n_fail++; $display("FAIL fwft_after_e0: got empty %b vld %b cnt %0d exp 0 0 1", b_empty, b_vld, b_cnt); end
    step();
    n_chk++; if (b_vld !== 1'b0) begin n_fail++; $display("FAIL fwft_after_e1: got vld %b exp 0", b_vld); end
    step();
    n_chk++; if (b_vld !== 1'b1 || b_data !== 8'hA5) begin n_fail++; $display("FAIL fwft_after_e2: got vld %b data %h exp 1 a5", b_vld, b_data); end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    n_chk++; if (b_vld !== 1'b0 || b_empty !== 1'b1 || b_cnt !== 4'd0) begin n_fail++; $display("FAIL fwft_pop: got vld %b empty %b cnt %0d exp 0 1 0", b_vld, b_empty, b_cnt); end
  endtask

  task automatic test_fwft_throughput();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h10 + i);
      step();
    end
    wr_en = 1'b0;
    step(); step(); step();
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_en = (i < 12); wr_data = 8'(8'h14 + i);
      if (b_vld !== 1'b1 || b_data !== 8'(8'h10 + i)) bad++;
      step();
    end
    idle();
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL fwft_stream: got %0d bubbles/bad words exp 0", bad); end
    n_chk++; if (b_vld !== 1'b0 || b_empty !== 1'b1 || b_udf !== 1'b0) begin n_fail++; $display("FAIL fwft_stream_end: got vld %b empty %b udf %b exp 0 1 0", b_vld, b_empty, b_udf); end
  endtask

  task automatic test_random();
    logic [7:0] qa[$], qb[$];
    logic [7:0] exp_a, wd;
    int cnt_a = 0, cnt_b = 0, pa = 0, pb = 0, errs = 0, cyc = 0;
    logic wa, ra, wb, pop_b;
    do_reset();
    while ((pa < 2000 || pb < 2000) && cyc < 20000) begin
      wr_en = ($urandom_range(0, 99) < 60);
      rd_en = ($urandom_range(0, 99) < 60);
      wr_data = 8'($urandom);
      wd = wr_data;
      wa = wr_en && (cnt_a < 8);
      ra = rd_en && (cnt_a > 0);
      wb = wr_en && (cnt_b < 8);
      pop_b = rd_en && b_vld;
      exp_a = 8'h00;
      if (ra) exp_a = qa.pop_front();
      if (pop_b) begin
        if (qb.size() == 0) errs++;
        else if (b_data !== qb.pop_front()) errs++;
        pb++;
      end
      step();
      if (ra) begin
        if (a_vld !== 1'b1 || a_data !== exp_a) errs++;
        pa++;
      end else if (a_vld !== 1'b0) errs++;
      if (wa) qa.push_back(wd);
      if (wb) qb.push_back(wd);
      cnt_a = cnt_a + int'(wa) - int'(ra);
      cnt_b = cnt_b + int'(wb) - int'(pop_b);
      if (a_cnt !== 4'(cnt_a) || b_cnt !== 4'(cnt_b)) errs++;
      cyc++;
    end
    idle();
    n_chk++; if (errs != 0) begin n_fail++; $display("FAIL random_scoreboard: got %0d errors exp 0", errs); end
    n_chk++; if (pa < 2000 || pb < 2000) begin n_fail++; $display("FAIL random_progress: got %0d/%0d words exp >=2000 each", pa, pb); end
  endtask

  task automatic test_thresholds();
    int cnt = 0;
    logic exp_af, exp_ae;
    do_reset();
    for (int rep = 0; rep < 3; rep++) begin
      for (int k = 0; k < 16; k++) begin
        wr_en = (k < 8); rd_en = (k >= 8); wr_data = 8'(rep * 16 + k);
        step();
        cnt = (k < 8) ? cnt + 1 : cnt - 1;
        exp_af = (cnt >= 6);
        exp_ae = (cnt <= 2);
        n_chk++; if ({a_af, a_ae, a_cnt} !== {exp_af, exp_ae, 4'(cnt)}) begin n_fail++; $display("FAIL thresh_std rep %0d: got af %b ae %b cnt %0d exp %b %b %0d", rep, a_af, a_ae, a_cnt, exp_af, exp_ae, cnt); end
        n_chk++; if ({b_af, b_ae, b_cnt} !== {exp_af, exp_ae, 4'(cnt)}) begin n_fail++; $display("FAIL thresh_fwft rep %0d: got af %b ae %b cnt %0d exp %b %b %0d", rep, b_af, b_ae, b_cnt, exp_af, exp_ae, cnt); end
      end
    end
    idle();
  endtask

  task automatic test_corner();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h40 + i);
      step();
    end
    wr_data = 8'hEE; rd_en = 1'b1;
    step();
    wr_en = 1'b0;
    n_chk++; if (a_ovf !== 1'b1 || a_cnt !== 4'd7 || a_vld !== 1'b1 || a_data !== 8'h40) begin n_fail++; $display("FAIL full_wr_rd_std: got ovf %b cnt %0d vld %b data %h exp 1 7 1 40", a_ovf, a_cnt, a_vld, a_data); end
    n_chk++; if (b_ovf !== 1'b1 || b_cnt !== 4'd7) begin n_fail++; $display("FAIL full_wr_rd_fwft: got ovf %b cnt %0d exp 1 7", b_ovf, b_cnt); end
    for (int i = 0; i < 7; i++) step();
    n_chk++; if ({a_cnt, b_cnt, a_udf, b_udf} !== 10'b0) begin n_fail++; $display("FAIL drain: got cnt %0d/%0d udf %b/%b exp 0/0 0/0", a_cnt, b_cnt, a_udf, b_udf); end
    n_chk++; if (a_data !== 8'h47) begin n_fail++; $display("FAIL drain_last: got %h exp 47", a_data); end
    step();
    rd_en = 1'b0;
    n_chk++; if (a_udf !== 1'b1 || b_udf !== 1'b1 || a_cnt !== 4'd0) begin n_fail++; $display("FAIL underflow: got %b/%b cnt %0d exp 1/1 0", a_udf, b_udf, a_cnt); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    n_chk++; if ({a_ovf, a_udf, b_ovf, b_udf} !== 4'b0000) begin n_fail++; $display("FAIL err_clr: got %b exp 0000", {a_ovf, a_udf, b_ovf, b_udf}); end
    err_clr = 1'b1; rd_en = 1'b1;
    step();
    idle();
    n_chk++; if ({a_ovf, a_udf, b_ovf, b_udf} !== 4'b0101) begin n_fail++; $display("FAIL err_clr_vs_new: got %b exp 0101", {a_ovf, a_udf, b_ovf, b_udf}); end
  endtask

  task automatic test_clr_reset();
    do_reset();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h50 + i);
      step();
    end
    wr_en = 1'b0;
    step(); step();
    clr = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hFF;
    step();
    idle();
    n_chk++; if (a_st !== 7'b0010101 || a_cnt !== 4'd0) begin n_fail++; $display("FAIL clr_std: got %b cnt %0d exp 0010101 cnt 0", a_st, a_cnt); end
    n_chk++; if (b_st !== 7'b0010101 || b_cnt !== 4'd0) begin n_fail++; $display("FAIL clr_fwft: got %b cnt %0d exp 0010101 cnt 0", b_st, b_cnt); end
    wr_en = 1'b1; wr_data = 8'h61;
    step();
    wr_data = 8'h62;
    step();
    wr_data = 8'h63;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (a_st !== 7'b0010100 || b_st !== 7'b0010100) begin n_fail++; $display("FAIL midburst_reset_status: got %b/%b exp 0010100", a_st, b_st); end
    n_chk++; if ({a_cnt, b_cnt, a_data, b_data} !== 24'h0) begin n_fail++; $display("FAIL midburst_reset_state: got cnt %0d/%0d data %h/%h exp 0", a_cnt, b_cnt, a_data, b_data); end
    step();
    rst_n = 1'b1;
    wr_data = 8'h3C;
    step();
    wr_data = 8'h3D;
    step();
    wr_en = 1'b0; rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    n_chk++; if (a_vld !== 1'b1 || a_data !== 8'h3C) begin n_fail++; $display("FAIL post_reset_std: got vld %b data %h exp 1 3c", a_vld, a_data); end
    n_chk++; if (b_vld !== 1'b1 || b_data !== 8'h3C) begin n_fail++; $display("FAIL post_reset_fwft: got vld %b data %h exp 1 3c", b_vld, b_data); end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_fwft_latency();
    test_fwft_throughput();
    test_random();
    test_thresholds();
    test_corner();
    test_clr_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
